// File: rtl/fft_sequencer.sv
// Control block for an N = 2^LOG2N point radix-2 DIT FFT: load, two-phase butterfly
// schedule over ping-pong BRAM banks, twiddle addressing and a valid/ready output stream.
module fft_sequencer #(
    parameter int unsigned LOG2N  = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              inverse,
    input  logic              load,
    input  logic [LOG2N-1:0]  load_address,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LOG2N-1:0]  out_index,
    output logic [DATA_W-1:0] data_out,
    output logic [LOG2N-1:0]  bank0_addr_a,
    output logic [LOG2N-1:0]  bank0_addr_b,
    output logic [LOG2N-1:0]  bank1_addr_a,
    output logic [LOG2N-1:0]  bank1_addr_b,
    output logic              bank0_we,
    output logic              bank1_we,
    output logic [DATA_W-1:0] wr_data_a,
    output logic [DATA_W-1:0] wr_data_b,
    input  logic [DATA_W-1:0] rd0_a,
    input  logic [DATA_W-1:0] rd0_b,
    input  logic [DATA_W-1:0] rd1_a,
    input  logic [DATA_W-1:0] rd1_b,
    output logic [DATA_W-1:0] bf_a,
    output logic [DATA_W-1:0] bf_b,
    input  logic [DATA_W-1:0] bf_a_out,
    input  logic [DATA_W-1:0] bf_b_out,
    output logic [LOG2N-2:0]  twiddle_addr,
    output logic              twiddle_conj
);

    localparam logic RES_BANK = (LOG2N % 2) == 1;

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_OUTPUT} state_t;

    state_t              state, state_nx;
    logic [3:0]          level;
    logic [LOG2N-2:0]    iter;
    logic                phase;
    logic                inv_r;
    logic                done_r;
    logic [LOG2N:0]      fetch_idx;
    logic                rd_pend;
    logic [LOG2N-1:0]    out_cnt;
    logic                out_v, skid_v;
    logic [DATA_W-1:0]   out_d, skid_d;

    logic [LOG2N-1:0]    iter_ext, span, mask, addr_a, addr_b;
    logic [LOG2N-2:0]    tw_idx;
    logic                last_bfly, pop, issue;
    logic [1:0]          occ;
    logic [DATA_W-1:0]   rd_data;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
        return r;
    endfunction

    always_comb begin
        iter_ext  = {1'b0, iter};
        span      = (LOG2N)'(1) << level;
        mask      = span - 1'b1;
        addr_a    = ((iter_ext >> level) << (level + 1'b1)) | (iter_ext & mask);
        addr_b    = addr_a + span;
        tw_idx    = (LOG2N-1)'((iter_ext & mask) << (4'(LOG2N - 1) - level));
        last_bfly = phase && (&iter) && (level == 4'(LOG2N - 1));
        rd_data   = RES_BANK ? rd1_a : rd0_a;
        pop       = out_v && out_ready;
        // Entries held after this cycle (out + skid, incl. arriving read); a new fetch needs a free slot.
        occ       = 2'(out_v) + 2'(skid_v) + 2'(rd_pend) - 2'(pop);
        issue     = (state == S_OUTPUT) && !fetch_idx[LOG2N] && (occ < 2'd2);
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (start) state_nx = S_COMPUTE;
            S_COMPUTE: if (last_bfly) state_nx = S_OUTPUT;
            S_OUTPUT:  if (pop && (&out_cnt)) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bank0_addr_a = '0;
        bank0_addr_b = '0;
        bank1_addr_a = '0;
        bank1_addr_b = '0;
        bank0_we     = 1'b0;
        bank1_we     = 1'b0;
        wr_data_a    = '0;
        wr_data_b    = '0;
        bf_a         = '0;
        bf_b         = '0;
        twiddle_addr = '0;
        case (state)
            S_IDLE: begin
                // Both ports target the same word so the shared write enable cannot clobber another entry.
                if (load && !start) begin
                    bank0_addr_a = bitrev(load_address);
                    bank0_addr_b = bitrev(load_address);
                    wr_data_a    = data_in;
                    wr_data_b    = data_in;
                    bank0_we     = 1'b1;
                end
            end
            S_COMPUTE: begin
                bank0_addr_a = addr_a;
                bank0_addr_b = addr_b;
                bank1_addr_a = addr_a;
                bank1_addr_b = addr_b;
                twiddle_addr = tw_idx;
                if (phase) begin
                    bf_a      = level[0] ? rd1_a : rd0_a;
                    bf_b      = level[0] ? rd1_b : rd0_b;
                    wr_data_a = bf_a_out;
                    wr_data_b = bf_b_out;
                    bank0_we  = level[0];
                    bank1_we  = !level[0];
                end
            end
            S_OUTPUT: begin
                if (RES_BANK) bank1_addr_a = fetch_idx[LOG2N-1:0];
                else          bank0_addr_a = fetch_idx[LOG2N-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            level     <= '0;
            iter      <= '0;
            phase     <= 1'b0;
            inv_r     <= 1'b0;
            done_r    <= 1'b0;
            fetch_idx <= '0;
            rd_pend   <= 1'b0;
            out_cnt   <= '0;
            out_v     <= 1'b0;
            skid_v    <= 1'b0;
            out_d     <= '0;
            skid_d    <= '0;
        end else begin
            state  <= state_nx;
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    level     <= '0;
                    iter      <= '0;
                    phase     <= 1'b0;
                    fetch_idx <= '0;
                    rd_pend   <= 1'b0;
                    out_cnt   <= '0;
                    out_v     <= 1'b0;
                    skid_v    <= 1'b0;
                    if (start) inv_r <= inverse;
                end
                S_COMPUTE: begin
                    phase <= ~phase;
                    if (phase) begin
                        iter <= iter + 1'b1;
                        if (&iter) level <= level + 1'b1;
                    end
                end
                S_OUTPUT: begin
                    rd_pend <= issue;
                    if (issue) fetch_idx <= fetch_idx + 1'b1;
                    if (!out_v || pop) begin
                        if (skid_v) begin
                            out_d  <= skid_d;
                            out_v  <= 1'b1;
                            skid_v <= rd_pend;
                            skid_d <= rd_data;
                        end else begin
                            out_v <= rd_pend;
                            out_d <= rd_data;
                        end
                    end else if (rd_pend) begin
                        skid_v <= 1'b1;
                        skid_d <= rd_data;
                    end
                    if (pop) begin
                        out_cnt <= out_cnt + 1'b1;
                        if (&out_cnt) done_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy         = (state != S_IDLE);
    assign done         = done_r;
    assign out_valid    = out_v;
    assign out_index    = out_cnt;
    assign data_out     = out_v ? out_d : '0;
    assign twiddle_conj = inv_r && (state != S_IDLE);

endmodule

// File: tb/tb_fft_sequencer.sv
// Scoreboard bench for fft_sequencer: two instances (LOG2N=6 and LOG2N=3) with BRAM,
// butterfly and twiddle behavioural models around them.
module tb_fft_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic reset;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Complex butterfly with a cos/sin twiddle; index 0 is exactly 1+0j.
    function automatic logic [63:0] bfly(input logic [31:0] a, input logic [31:0] b,
                                         input int tw, input int n, input logic conj);
        logic signed [15:0] ar, ai, br, bi;
        int tr, ti;
        real ang, c, s;
        ar = a[31:16]; ai = a[15:0]; br = b[31:16]; bi = b[15:0];
        if (tw == 0) begin
            tr = br; ti = bi;
        end else begin
            ang = 6.283185307179586 * real'(tw) / real'(n);
            c = $cos(ang);
            s = conj ? $sin(ang) : -$sin(ang);
            tr = int'(real'(br) * c - real'(bi) * s);
            ti = int'(real'(br) * s + real'(bi) * c);
        end
        return {16'(ar + tr), 16'(ai + ti), 16'(ar - tr), 16'(ai - ti)};
    endfunction

    // ---------------- LOG2N = 6 instance ----------------
    logic start6, inv6, load6, ready6;
    logic [5:0] la6, oi6, a0a6, a0b6, a1a6, a1b6;
    logic [31:0] din6, do6, wda6, wdb6, r0a6, r0b6, r1a6, r1b6, bfa6, bfb6, bfao6, bfbo6;
    logic busy6, done6, ov6, we0_6, we1_6, conj6;
    logic [4:0] tw6;
    logic [31:0] m60 [64];
    logic [31:0] m61 [64];

    fft_sequencer #(.LOG2N(6), .DATA_W(32)) u_fft6 (
        .clk(clk), .reset(reset), .start(start6), .inverse(inv6), .load(load6),
        .load_address(la6), .data_in(din6), .busy(busy6), .done(done6),
        .out_valid(ov6), .out_ready(ready6), .out_index(oi6), .data_out(do6),
        .bank0_addr_a(a0a6), .bank0_addr_b(a0b6), .bank1_addr_a(a1a6), .bank1_addr_b(a1b6),
        .bank0_we(we0_6), .bank1_we(we1_6), .wr_data_a(wda6), .wr_data_b(wdb6),
        .rd0_a(r0a6), .rd0_b(r0b6), .rd1_a(r1a6), .rd1_b(r1b6),
        .bf_a(bfa6), .bf_b(bfb6), .bf_a_out(bfao6), .bf_b_out(bfbo6),
        .twiddle_addr(tw6), .twiddle_conj(conj6));

    always @(posedge clk) begin
        if (we0_6) begin m60[a0a6] <= wda6; m60[a0b6] <= wdb6; end
        if (we1_6) begin m61[a1a6] <= wda6; m61[a1b6] <= wdb6; end
        r0a6 <= m60[a0a6]; r0b6 <= m60[a0b6]; r1a6 <= m61[a1a6]; r1b6 <= m61[a1b6];
    end
    always_comb {bfao6, bfbo6} = bfly(bfa6, bfb6, int'(tw6), 64, conj6);

    // ---------------- LOG2N = 3 instance ----------------
    logic start3, inv3, load3, ready3;
    logic [2:0] la3, oi3, a0a3, a0b3, a1a3, a1b3;
    logic [31:0] din3, do3, wda3, wdb3, r0a3, r0b3, r1a3, r1b3, bfa3, bfb3, bfao3, bfbo3;
    logic busy3, done3, ov3, we0_3, we1_3, conj3;
    logic [1:0] tw3;
    logic [31:0] m30 [8];
    logic [31:0] m31 [8];

    fft_sequencer #(.LOG2N(3), .DATA_W(32)) u_fft3 (
        .clk(clk), .reset(reset), .start(start3), .inverse(inv3), .load(load3),
        .load_address(la3), .data_in(din3), .busy(busy3), .done(done3),
        .out_valid(ov3), .out_ready(ready3), .out_index(oi3), .data_out(do3),
        .bank0_addr_a(a0a3), .bank0_addr_b(a0b3), .bank1_addr_a(a1a3), .bank1_addr_b(a1b3),
        .bank0_we(we0_3), .bank1_we(we1_3), .wr_data_a(wda3), .wr_data_b(wdb3),
        .rd0_a(r0a3), .rd0_b(r0b3), .rd1_a(r1a3), .rd1_b(r1b3),
        .bf_a(bfa3), .bf_b(bfb3), .bf_a_out(bfao3), .bf_b_out(bfbo3),
        .twiddle_addr(tw3), .twiddle_conj(conj3));

    always @(posedge clk) begin
        if (we0_3) begin m30[a0a3] <= wda3; m30[a0b3] <= wdb3; end
        if (we1_3) begin m31[a1a3] <= wda3; m31[a1b3] <= wdb3; end
        r0a3 <= m30[a0a3]; r0b3 <= m30[a0b3]; r1a3 <= m31[a1a3]; r1b3 <= m31[a1b3];
    end
    always_comb {bfao3, bfbo3} = bfly(bfa3, bfb3, int'(tw3), 8, conj3);

    // ---------------- scoreboards and monitors ----------------
    logic [39:0] q6[$];
    logic [39:0] q3[$];
    int dcnt6 = 0, dcnt3 = 0, weboth = 0;
    logic hold6 = 1'b0, hold3 = 1'b0, xdone6 = 1'b0, xdone3 = 1'b0;
    logic [39:0] held6, held3;

    always @(negedge clk) begin
        if (we0_6 && we1_6) weboth++;
        if (done6) dcnt6++;
        if (xdone6) begin
            check("done6_after_last", {62'd0, done6, ov6}, 64'b10);
            xdone6 = 1'b0;
        end
        if (hold6) check("stall6_hold", {24'd0, 2'b00, oi6, do6}, {24'd0, held6});
        hold6 = ov6 && !ready6;
        held6 = {2'b00, oi6, do6};
        if (ov6 && ready6) begin
            if (q6.size() == 0) begin
                tests++; fails++;
                $display("FAIL bin6_unexpected: got index %0d data 0x%0h, expected no output", oi6, do6);
            end else begin
                check("bin6", {24'd0, 2'b00, oi6, do6}, {24'd0, q6.pop_front()});
            end
            if (oi6 == 6'd63) xdone6 = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (we0_3 && we1_3) weboth++;
        if (done3) dcnt3++;
        if (xdone3) begin
            check("done3_after_last", {62'd0, done3, ov3}, 64'b10);
            xdone3 = 1'b0;
        end
        if (hold3) check("stall3_hold", {24'd0, 5'd0, oi3, do3}, {24'd0, held3});
        hold3 = ov3 && !ready3;
        held3 = {5'd0, oi3, do3};
        if (ov3 && ready3) begin
            if (q3.size() == 0) begin
                tests++; fails++;
                $display("FAIL bin3_unexpected: got index %0d data 0x%0h, expected no output", oi3, do3);
            end else begin
                check("bin3", {24'd0, 5'd0, oi3, do3}, {24'd0, q3.pop_front()});
            end
            if (oi3 == 3'd7) xdone3 = 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load6_one(input int a, input logic [31:0] v);
        load6 = 1'b1; la6 = 6'(a); din6 = v; tick(); load6 = 1'b0;
    endtask

    task automatic load3_one(input int a, input logic [31:0] v);
        load3 = 1'b1; la3 = 3'(a); din3 = v; tick(); load3 = 1'b0;
    endtask

    task automatic start3_pulse(input logic inv);
        start3 = 1'b1; inv3 = inv; tick(); start3 = 1'b0; inv3 = 1'b0;
    endtask

    // Waits for out_valid (latency from compute cycle 0) then for done, with ready held at 1.
    task automatic run3_plain(input string tag, input int exp_lat);
        int n;
        int base;
        base = dcnt3;
        n = 0;
        while (!ov3 && n < 100) begin tick(); n++; end
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        n = 0;
        while (!done3 && n < 100) begin tick(); n++; end
        check({tag, "_throughput"}, 64'(n), 64'd8);
        tick();
        check({tag, "_done_count"}, 64'(dcnt3 - base), 64'd1);
        check({tag, "_drained"}, 64'(q3.size()), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int n;
        int base;
        reset = 1'b0;
        {start6, inv6, load6, ready6, la6, din6} = '0;
        {start3, inv3, load3, ready3, la3, din3} = '0;
        tick(); tick();
        check("reset3_ctrl", {56'd0, busy3, done3, ov3, we0_3, we1_3, conj3, tw3},  64'd0);
        check("reset3_data", {29'd0, oi3, do3}, 64'd0);
        check("reset6_ctrl", {56'd0, busy6, done6, ov6, we0_6, we1_6, conj6, 2'b00}, 64'd0);
        reset = 1'b1;
        tick();
        check("idle3_quiet", {32'd0, 21'd0, we0_3, we1_3, busy3, tw3, a0a3, a1a3}, 64'd0);

        // LOG2N=6: DC input, 384 compute cycles, bin 0 = 64x.
        ready6 = 1'b1;
        for (int k = 0; k < 64; k++) load6_one(k, 32'h0001_0000);
        q6.push_back({8'd0, 32'h0040_0000});
        for (int k = 1; k < 64; k++) q6.push_back({8'(k), 32'h0});
        base = dcnt6;
        start6 = 1'b1; tick(); start6 = 1'b0;
        check("busy6_c0", 64'(busy6), 64'd1);
        n = 0;
        while (!ov6 && n < 1000) begin tick(); n++; end
        check("latency6", 64'(n), 64'd386);
        n = 0;
        while (!done6 && n < 200) begin tick(); n++; end
        check("throughput6", 64'(n), 64'd64);
        tick();
        check("done6_count", 64'(dcnt6 - base), 64'd1);
        check("drained6", 64'(q6.size()), 64'd0);
        check("idle6_after", {62'd0, busy6, ov6}, 64'd0);

        // LOG2N=3: load address bit reversal.
        load3 = 1'b1; la3 = 3'd1; din3 = 32'h0; #1;
        check("load3_bitrev", {59'd0, a0a3, we0_3, we1_3}, {59'd0, 3'd4, 1'b1, 1'b0});
        tick(); load3 = 1'b0;

        // Impulse; start collides with a load (dropped), start retried while busy, stalled output.
        load3_one(0, 32'h0100_0000);
        for (int k = 1; k < 8; k++) load3_one(k, 32'h0);
        for (int k = 0; k < 8; k++) q3.push_back({8'(k), 32'h0100_0000});
        base = dcnt3;
        load3 = 1'b1; la3 = 3'd0; din3 = 32'hdead_beef; start3 = 1'b1; #1;
        check("start_beats_load", {62'd0, we0_3, we1_3}, 64'd0);
        tick();
        load3 = 1'b0; start3 = 1'b0;
        check("conj3_fwd", 64'(conj3), 64'd0);
        n = 0;
        while (!ov3 && n < 100) begin
            tick(); n++;
            if (n == 3) start3 = 1'b1;
            if (n == 4) start3 = 1'b0;
            if (n == 14) check("trace_l1_i3", {54'd0, a1a3, a1b3, tw3, we0_3, we1_3},
                               {54'd0, 3'd5, 3'd7, 2'd2, 2'b00});
            if (n == 15) check("trace_l1_i3_wr", {54'd0, a0a3, a0b3, tw3, we0_3, we1_3},
                               {54'd0, 3'd5, 3'd7, 2'd2, 2'b10});
        end
        check("latency3_restart_ignored", 64'(n), 64'd26);
        n = 0;
        while (!done3 && n < 200) begin ready3 = pat[n % 4]; tick(); n++; end
        check("done3_stall_seen", 64'(done3), 64'd1);
        ready3 = 1'b1;
        tick();
        check("done3_stall_count", 64'(dcnt3 - base), 64'd1);
        check("drained3_stall", 64'(q3.size()), 64'd0);

        // IFFT of the previous result: all bins 0x0100 -> 8x impulse.
        for (int k = 0; k < 8; k++) load3_one(k, 32'h0100_0000);
        q3.push_back({8'd0, 32'h0800_0000});
        for (int k = 1; k < 8; k++) q3.push_back({8'(k), 32'h0});
        start3_pulse(1'b1);
        check("conj3_c0", 64'(conj3), 64'd1);
        repeat (23) tick();
        check("conj3_c23", {62'd0, conj3, busy3}, 64'b11);
        n = 0;
        while (!ov3 && n < 100) begin tick(); n++; end
        check("conj3_output", 64'(conj3), 64'd1);
        n = 0;
        base = dcnt3;
        while (!done3 && n < 100) begin tick(); n++; end
        check("ifft3_throughput", 64'(n), 64'd8);
        tick();
        check("ifft3_done_count", 64'(dcnt3 - base), 64'd1);
        check("ifft3_drained", 64'(q3.size()), 64'd0);

        // Reset during level 2, then a fresh frame.
        for (int k = 0; k < 8; k++) load3_one(k, 32'h0002_0000);
        start3_pulse(1'b0);
        repeat (17) tick();
        reset = 1'b0;
        #2;
        check("midreset3", {61'd0, busy3, ov3, done3}, 64'd0);
        tick();
        reset = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) load3_one(k, 32'h0001_0000);
        q3.push_back({8'd0, 32'h0008_0000});
        for (int k = 1; k < 8; k++) q3.push_back({8'(k), 32'h0});
        start3_pulse(1'b0);
        run3_plain("postreset3", 26);

        check("we_exclusive", 64'(weboth), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fft_sequencer.md
Name: fft_sequencer

Overview:
- Parametrised next-generation FFT control block for N = 2^LOG2N points.
- Owns the load, compute and output FSM, the ping-pong address generation, the twiddle addressing and the output stream handshake.
- Replaces the divided-clock scheme with a single-clock two-phase butterfly schedule.
- Drives two external dual-port BRAM banks, the existing butterfly_unit and twiddle_rom through ports; adds inverse-FFT mode and a valid/ready output stream.

Parameters:
- LOG2N, 6, log2 of the transform length; legal range 3..10.
- DATA_W, 32, complex sample width (upper half real, lower half imaginary).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins compute when IDLE
- inverse  in  1  sampled on accepted start; 1 selects IFFT
- load  in  1  write data_in into bank 0 (IDLE only)
- load_address  in  LOG2N  natural-order sample index
- data_in  in  DATA_W  sample to load
- busy  out  1  high in COMPUTE or OUTPUT
- done  out  1  one-cycle pulse after last output handshake
- out_valid  out  1  data_out valid
- out_ready  in  1  sink accepts data_out
- out_index  out  LOG2N  frequency bin of data_out
- data_out  out  DATA_W  result sample
- bank0_addr_a, bank0_addr_b, bank1_addr_a, bank1_addr_b  out  LOG2N  BRAM addresses
- bank0_we, bank1_we  out  1  write enables (both ports)
- wr_data_a, wr_data_b  out  DATA_W  BRAM write data
- rd0_a, rd0_b, rd1_a, rd1_b  in  DATA_W  BRAM read data (1-cycle latency)
- bf_a, bf_b  out  DATA_W  butterfly inputs
- bf_a_out, bf_b_out  in  DATA_W  butterfly results (combinational)
- twiddle_addr  out  LOG2N-1  twiddle ROM index
- twiddle_conj  out  1  latched inverse flag; datapath conjugates twiddle

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, level=0, iter=0, phase=0, out_index=0; all outputs 0.
- IDLE:
  - load=1 writes bank 0 at bit-reverse(load_address) on port A; wr_data_a=data_in; bank0_we=1 the same cycle.
  - start=1 latches inverse and goes to COMPUTE. If start and load are both high, start wins and the load is dropped.
- COMPUTE:
  - Counters: level 0..LOG2N-1, iter 0..N/2-1, phase 0/1.
  - Address generation: span=1<<level; a=((iter>>level)<<(level+1)) | (iter & (span-1)); b=a+span; twiddle_addr=(iter & (span-1))<<(LOG2N-1-level).
  - Banks: read from bank level[0], write to the other bank at the same a/b.
  - Phase 0: issue read address, we=0.
  - Phase 1: bf_a/bf_b = selected bank read data, wr_data = bf_a_out/bf_b_out, write bank we=1, then advance iter (wrap → level+1).
  - Each butterfly takes 2 cycles. Compute is N*LOG2N cycles total (384 for defaults).
  - After the last write, go to OUTPUT. Result bank is LOG2N[0] (bank 0 if LOG2N is even).
- OUTPUT:
  - Read the result bank port A at out_index; 1-cycle prefetch with a 1-entry skid register.
  - out_valid rises 2 cycles after entering OUTPUT and holds data_out/out_index stable until out_ready.
  - Each handshake advances out_index. Output order is natural order 0..N-1.
  - After the handshake at index N-1: done=1 for one cycle, out_valid=0, return to IDLE.
  - With out_ready held at 1, sustained throughput is 1 sample per cycle.
- Ignored inputs: start while busy; load outside IDLE; inverse outside the start cycle.
- Reset mid-operation: immediate return to IDLE. Bank contents are undefined; the new frame must be reloaded.
- Write enable rule: bank0_we and bank1_we are never both 1.
- Scaling: none in this block; IDLE→IDLE with no start keeps every output at 0 except the load path.

Test Plan:
- LOG2N=6: load x[k]=0x0001_0000 for all k, start -> busy for 384 compute cycles. Output bin 0 = 0x0040_0000, bins 1..63 = 0. done pulses once after the 64th handshake.
- LOG2N=3: load impulse x[0]=0x0100_0000, rest 0 -> all 8 bins = 0x0100_0000 in order 0..7. Check address trace at level 1, iter 3: a=5, b=7, twiddle_addr=2.
- LOG2N=3: load load_address=1 -> bank0_addr_a=4 with bank0_we=1. Start while busy -> no restart, cycle count unchanged.
- Inverse=1 then FFT then IFFT of the result -> twiddle_conj=1 throughout. Output equals N×input (no scaling).
- OUTPUT stall: toggle out_ready 1,0,0,1 -> data_out and out_index hold during the 0s, no sample lost or duplicated.
- Reset asserted at level 2 and released -> IDLE, busy=0, out_valid=0. A new load/start completes correctly.
